// File: rtl/rv32i_instr_encoder_if.sv
// ---------------------------------------------------------------------------
// rv32i_instr_encoder_if
//   Bundle between a program loader and the RV32I instruction encoder.
//   Signal names carry the encoder's point of view: i_* flows into the
//   encoder, o_* flows out of it.
//
//   Control     : i_start (pulse, begins a new program)
//   Descriptor  : i_in_valid / o_in_ready handshake plus i_in_fmt, i_in_op,
//                 i_in_funct3, i_in_funct7, i_in_rd, i_in_rs1, i_in_rs2,
//                 i_in_imm
//   IMEM write  : o_out_valid / i_out_ready handshake plus o_out_instr,
//                 o_out_addr (byte address, ADDR_W bits)
//   Status      : o_count (descriptors accepted), o_done (halt delivered),
//                 o_err (illegal format / immediate out of range)
//
//   Modports: slave  = encoder side
//             master = loader / sink side
// ---------------------------------------------------------------------------
interface rv32i_instr_encoder_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              i_start;
    logic              i_in_valid;
    logic              o_in_ready;
    logic [2:0]        i_in_fmt;
    logic [6:0]        i_in_op;
    logic [2:0]        i_in_funct3;
    logic [6:0]        i_in_funct7;
    logic [4:0]        i_in_rd;
    logic [4:0]        i_in_rs1;
    logic [4:0]        i_in_rs2;
    logic [31:0]       i_in_imm;
    logic              o_out_valid;
    logic              i_out_ready;
    logic [31:0]       o_out_instr;
    logic [ADDR_W-1:0] o_out_addr;
    logic [15:0]       o_count;
    logic              o_done;
    logic              o_err;

    modport slave (
        input  i_start,
        input  i_in_valid,
        output o_in_ready,
        input  i_in_fmt,
        input  i_in_op,
        input  i_in_funct3,
        input  i_in_funct7,
        input  i_in_rd,
        input  i_in_rs1,
        input  i_in_rs2,
        input  i_in_imm,
        output o_out_valid,
        input  i_out_ready,
        output o_out_instr,
        output o_out_addr,
        output o_count,
        output o_done,
        output o_err
    );

    modport master (
        output i_start,
        output i_in_valid,
        input  o_in_ready,
        output i_in_fmt,
        output i_in_op,
        output i_in_funct3,
        output i_in_funct7,
        output i_in_rd,
        output i_in_rs1,
        output i_in_rs2,
        output i_in_imm,
        input  o_out_valid,
        output i_out_ready,
        input  o_out_instr,
        input  o_out_addr,
        input  o_count,
        input  o_done,
        input  o_err
    );
endinterface

// File: rtl/rv32i_instr_encoder.sv
// ---------------------------------------------------------------------------
// rv32i_instr_encoder
//   Packs RV32I instruction field descriptors into 32-bit instruction words
//   and streams them, each with its IMEM byte address, to the instruction
//   memory write port. Used by the boot/test loader to build programs.
//   Encoding stops after a halt instruction (ECALL/EBREAK); once that word
//   has been delivered, done is raised and held until the next start.
//
//   Parameters
//     ADDR_W     width of the byte address
//     BASE_ADDR  address of the first word after start
//     ADDR_STEP  address increment per accepted descriptor
//
//   Ports
//     clk  rising-edge clock
//     rst  asynchronous, active-high reset
//     bus  rv32i_instr_encoder_if.slave (start, descriptor handshake,
//          IMEM write handshake, count/done/err status)
//
//   Build option
//     IMM_RANGE_CHECK_EN  when defined, immediates that the selected format
//                         cannot represent also set err (the word is still
//                         built from the truncated bits). When undefined,
//                         immediates are silently truncated and err only
//                         flags an illegal format.
// ---------------------------------------------------------------------------
module rv32i_instr_encoder #(
    parameter int unsigned       ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       ADDR_STEP = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rv32i_instr_encoder_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [2:0]        FMT_R     = 3'b000;
    localparam logic [2:0]        FMT_I     = 3'b001;
    localparam logic [2:0]        FMT_S     = 3'b010;
    localparam logic [2:0]        FMT_B     = 3'b011;
    localparam logic [2:0]        FMT_U     = 3'b100;
    localparam logic [2:0]        FMT_J     = 3'b101;
    localparam logic [6:0]        OP_SYSTEM = 7'b1110011;
    localparam logic [31:0]       NOP_WORD  = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            r_state;
    logic              r_out_valid;
    logic [31:0]       r_out_instr;
    logic [ADDR_W-1:0] r_out_addr;
    logic [ADDR_W-1:0] r_addr;      // address the next accepted word gets
    logic [15:0]       r_count;
    logic              r_done;
    logic              r_err;

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic w_in_ready;
    logic w_accept;
    logic w_out_hs;

    // The single output register may be reloaded in the same cycle its
    // current word is taken, giving one word per cycle.
    assign w_in_ready = (r_state == ST_RUN) && (!r_out_valid || bus.i_out_ready);
    assign w_accept   = bus.i_in_valid && w_in_ready;
    assign w_out_hs   = r_out_valid && bus.i_out_ready;

    // ------------------------------------------------------------------
    // Field packing
    // ------------------------------------------------------------------
    logic [31:0] w_imm;
    logic [31:0] w_word;
    logic        w_fmt_bad;

    assign w_imm = bus.i_in_imm;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path can leave it unassigned and infer a latch.
        w_word    = NOP_WORD;
        w_fmt_bad = 1'b0;
        case (bus.i_in_fmt)
            FMT_R: w_word = {bus.i_in_funct7, bus.i_in_rs2, bus.i_in_rs1,
                             bus.i_in_funct3, bus.i_in_rd, bus.i_in_op};
            FMT_I: w_word = {w_imm[11:0], bus.i_in_rs1, bus.i_in_funct3,
                             bus.i_in_rd, bus.i_in_op};
            FMT_S: w_word = {w_imm[11:5], bus.i_in_rs2, bus.i_in_rs1,
                             bus.i_in_funct3, w_imm[4:0], bus.i_in_op};
            FMT_B: w_word = {w_imm[12], w_imm[10:5], bus.i_in_rs2, bus.i_in_rs1,
                             bus.i_in_funct3, w_imm[4:1], w_imm[11], bus.i_in_op};
            FMT_U: w_word = {w_imm[31:12], bus.i_in_rd, bus.i_in_op};
            FMT_J: w_word = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12],
                             bus.i_in_rd, bus.i_in_op};
            default: w_fmt_bad = 1'b1;   // 110/111: emit a NOP and flag it
        endcase
    end

    // ------------------------------------------------------------------
    // Immediate representability
    // ------------------------------------------------------------------
    logic w_imm_bad;

`ifdef IMM_RANGE_CHECK_EN
    // A signed value fits in N bits when every bit from N-1 upward equals
    // the sign; branch/jump offsets must additionally be even.
    logic w_fits12;
    logic w_fits13;
    logic w_fits21;

    assign w_fits12 = (w_imm[31:11] == '0) || (w_imm[31:11] == '1);
    assign w_fits13 = (w_imm[31:12] == '0) || (w_imm[31:12] == '1);
    assign w_fits21 = (w_imm[31:20] == '0) || (w_imm[31:20] == '1);

    always_comb begin
        w_imm_bad = 1'b0;
        case (bus.i_in_fmt)
            FMT_I, FMT_S: w_imm_bad = !w_fits12;
            FMT_B:        w_imm_bad = !w_fits13 || w_imm[0];
            FMT_U:        w_imm_bad = (w_imm[11:0] != 12'h000);
            FMT_J:        w_imm_bad = !w_fits21 || w_imm[0];
            default:      w_imm_bad = 1'b0;
        endcase
    end
`else
    assign w_imm_bad = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Halt detection: ECALL (imm 0) or EBREAK (imm 1)
    // ------------------------------------------------------------------
    logic w_halt;

    assign w_halt = (bus.i_in_op == OP_SYSTEM) && (bus.i_in_funct3 == 3'b000)
                 && (w_imm[11:1] == 11'd0);

    // ------------------------------------------------------------------
    // Control FSM and output register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values and ordering inside the block
    // does not matter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_out_instr <= '0;
            r_out_addr  <= BASE_ADDR;
            r_addr      <= BASE_ADDR;
            r_count     <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.i_start) begin
                        r_state <= ST_RUN;
                        r_addr  <= BASE_ADDR;
                        r_count <= '0;
                        r_err   <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Stop taking descriptors once a halt is accepted.
                    if (w_accept && w_halt) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The halt is the only word in flight here.
                    if (w_out_hs) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_instr <= w_word;
                r_out_addr  <= r_addr;
                r_addr      <= r_addr + STEP;   // wraps modulo 2^ADDR_W
                if (r_count != 16'hFFFF) begin
                    r_count <= r_count + 16'd1;
                end
                if (w_fmt_bad || w_imm_bad) begin
                    r_err <= 1'b1;
                end
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.o_in_ready  = w_in_ready;
    assign bus.o_out_valid = r_out_valid;
    assign bus.o_out_instr = r_out_instr;
    assign bus.o_out_addr  = r_out_addr;
    assign bus.o_count     = r_count;
    assign bus.o_done      = r_done;
    assign bus.o_err       = r_err;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_rv32i_instr_encoder
//   Drives descriptors into rv32i_instr_encoder and checks the IMEM write
//   stream against a reference model. A driver pushes the expected word for
//   every accepted descriptor into a queue; an independent monitor pops and
//   compares whenever the encoder hands a word to the sink.
// ---------------------------------------------------------------------------
module tb_rv32i_instr_encoder;

    localparam int ADDR_W = 10;
    localparam int BASE   = 0;
    localparam int STEP   = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    rv32i_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    rv32i_instr_encoder #(
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (10'(BASE)),
        .ADDR_STEP (STEP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } desc_t;

    typedef struct {
        logic [31:0] instr;
        int          addr;
        int          cnt;
        bit          err;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;

    // Model state
    int m_addr;
    int m_cnt;
    bit m_err;

    // Sink readiness: random unless the main sequence pins it.
    bit rdy_force = 1'b1;
    bit rdy_val   = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: place each field at its bit position arithmetically
    // ------------------------------------------------------------------
    function automatic int unsigned bits(input int unsigned v, input int lo, input int hi);
        return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 1);
    endfunction

    function automatic logic [31:0] ref_word(input desc_t d);
        int unsigned im  = d.imm;
        int unsigned op  = d.op;
        int unsigned rd  = d.rd;
        int unsigned rs1 = d.rs1;
        int unsigned rs2 = d.rs2;
        int unsigned f3  = d.f3;
        int unsigned f7  = d.f7;
        case (d.fmt)
            3'd0: return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            3'd1: return ((im % 4096) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            3'd2: return (bits(im, 5, 11) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                       | (bits(im, 0, 4) << 7) | op;
            3'd3: return (bits(im, 12, 12) << 31) | (bits(im, 5, 10) << 25) | (rs2 << 20)
                       | (rs1 << 15) | (f3 << 12) | (bits(im, 1, 4) << 8)
                       | (bits(im, 11, 11) << 7) | op;
            3'd4: return (im & 32'hFFFF_F000) | (rd << 7) | op;
            3'd5: return (bits(im, 20, 20) << 31) | (bits(im, 1, 10) << 21)
                       | (bits(im, 11, 11) << 20) | (bits(im, 12, 19) << 12) | (rd << 7) | op;
            default: return 32'h0000_0013;
        endcase
    endfunction

    function automatic bit ref_bad(input desc_t d);
        int s = int'(d.imm);
        if (d.fmt > 3'd5) return 1'b1;
`ifdef IMM_RANGE_CHECK_EN
        case (d.fmt)
            3'd1, 3'd2: return (s < -2048) || (s > 2047);
            3'd3:       return (s < -4096) || (s > 4094) || (s % 2 != 0);
            3'd4:       return (d.imm % 4096) != 0;
            3'd5:       return (s < -1048576) || (s > 1048574) || (s % 2 != 0);
            default:    return 1'b0;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit ref_halt(input desc_t d);
        return (d.op == 7'h73) && (d.f3 == 3'd0) && ((d.imm % 4096) <= 1);
    endfunction

    function automatic desc_t mk(input int fmt, input int op, input int f3, input int f7,
                                 input int rd, input int rs1, input int rs2, input int imm);
        desc_t d;
        d.fmt = 3'(fmt); d.op = 7'(op); d.f3 = 3'(f3); d.f7 = 7'(f7);
        d.rd = 5'(rd); d.rs1 = 5'(rs1); d.rs2 = 5'(rs2); d.imm = 32'(imm);
        return d;
    endfunction

    function automatic desc_t rand_desc();
        desc_t d;
        d.fmt = ($urandom_range(0, 63) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
        d.op  = 7'($urandom);
        d.f3  = 3'($urandom);
        d.f7  = 7'($urandom);
        d.rd  = 5'($urandom);
        d.rs1 = 5'($urandom);
        d.rs2 = 5'($urandom);
        case ($urandom_range(0, 2))
            0:       d.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            1:       d.imm = 32'($urandom_range(0, 32'h3FFFFF)) - 32'h200000;
            default: d.imm = $urandom;
        endcase
        if (ref_halt(d)) d.op = d.op ^ 7'h01;
        return d;
    endfunction

    task automatic drive(input desc_t d);
        bus.i_in_fmt    = d.fmt;
        bus.i_in_op     = d.op;
        bus.i_in_funct3 = d.f3;
        bus.i_in_funct7 = d.f7;
        bus.i_in_rd     = d.rd;
        bus.i_in_rs1    = d.rs1;
        bus.i_in_rs2    = d.rs2;
        bus.i_in_imm    = d.imm;
    endtask

    // Present one descriptor until accepted; record the expected word.
    // Called between a falling edge and the next rising edge; returns at a
    // falling edge with in_valid low.
    task automatic send(input desc_t d, input bit use_lit, input logic [31:0] lit);
        int   waited = 0;
        exp_t e;
        drive(d);
        bus.i_in_valid = 1'b1;
        #1;
        while (!bus.o_in_ready && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!bus.o_in_ready) begin
            fail_now("accept_timeout");
        end else begin
            if (m_cnt < 65535) m_cnt++;
            if (ref_bad(d)) m_err = 1'b1;
            e.instr = use_lit ? lit : ref_word(d);
            e.addr  = m_addr;
            e.cnt   = m_cnt;
            e.err   = m_err;
            sb.push_back(e);
            m_addr = (m_addr + STEP) % (1 << ADDR_W);
        end
        @(negedge clk);
        bus.i_in_valid = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        m_addr = BASE;
        m_cnt  = 0;
        m_err  = 1'b0;
        #1;
        check("start_count", 32'(bus.o_count), 32'd0);
        check("start_err",   32'(bus.o_err),   32'd0);
        check("start_done",  32'(bus.o_done),  32'd0);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) fail_now(name);
    endtask

    task automatic set_ready(input bit force_en, input bit val);
        rdy_force = force_en;
        rdy_val   = val;
        if (force_en) bus.i_out_ready = val;
    endtask

    always @(negedge clk) begin
        bus.i_out_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.o_out_valid && bus.i_out_ready) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_word");
                end else begin
                    e = sb.pop_front();
                    check("out_instr", bus.o_out_instr, e.instr);
                    check("out_addr",  32'(bus.o_out_addr), 32'(e.addr));
                    check("count",     32'(bus.o_count), 32'(e.cnt));
                    check("err",       32'(bus.o_err), 32'(e.err));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin : main
        desc_t d;
        int    n;

        rst            = 1'b1;
        bus.i_start    = 1'b0;
        bus.i_in_valid = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
        bus.i_out_ready = 1'b1;
        m_addr = BASE; m_cnt = 0; m_err = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_in_ready",  32'(bus.o_in_ready),  32'd0);
        check("rst_out_valid", 32'(bus.o_out_valid), 32'd0);
        check("rst_out_instr", bus.o_out_instr,      32'd0);
        check("rst_out_addr",  32'(bus.o_out_addr),  32'(BASE));
        check("rst_count",     32'(bus.o_count),     32'd0);
        check("rst_done",      32'(bus.o_done),      32'd0);
        check("rst_err",       32'(bus.o_err),       32'd0);

        // Directed words with hand-encoded results
        set_ready(1'b1, 1'b1);
        do_start();
        send(mk(1, 7'h13, 0, 0, 1, 0, 0, 5),               1'b1, 32'h0050_0093);  // addi
        send(mk(2, 7'h23, 2, 0, 0, 1, 2, 8),               1'b1, 32'h0020_A423);  // sw
        send(mk(3, 7'h63, 0, 0, 0, 1, 2, -4),              1'b1, 32'hFE20_8EE3);  // beq
        send(mk(5, 7'h6F, 0, 0, 1, 0, 0, 8),               1'b1, 32'h0080_00EF);  // jal
        send(mk(4, 7'h37, 0, 0, 5, 0, 0, 32'h1234_5000),   1'b1, 32'h1234_52B7);  // lui
        wait_drain("drain_directed");

        // Back-pressure: sink stalls for 3 cycles while a descriptor waits
        @(negedge clk);
        set_ready(1'b1, 1'b0);
        send(mk(0, 7'h33, 0, 7'h00, 3, 1, 2, 0), 1'b1, 32'h0020_81B3);           // add
        n = sb[$].addr;
        for (int i = 0; i < 3; i++) begin
            drive(mk(0, 7'h33, 0, 7'h20, 4, 1, 2, 0));
            bus.i_in_valid = 1'b1;
            #1;
            check("stall_in_ready",  32'(bus.o_in_ready),  32'd0);
            check("stall_out_valid", 32'(bus.o_out_valid), 32'd1);
            check("stall_out_instr", bus.o_out_instr,      32'h0020_81B3);
            check("stall_out_addr",  32'(bus.o_out_addr),  32'(n));
            @(negedge clk);
        end
        set_ready(1'b1, 1'b1);
        send(mk(0, 7'h33, 0, 7'h20, 4, 1, 2, 0), 1'b1, 32'h4020_8233);           // sub
        wait_drain("drain_stall");

        // Randomized stream with random sink back-pressure (wraps the address)
        set_ready(1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            d = rand_desc();
            send(d, 1'b0, 32'd0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        // EBREAK terminates the program
        send(mk(1, 7'h73, 0, 0, 0, 0, 0, 1), 1'b1, 32'h0010_0073);
        #1;
        check("drain_in_ready", 32'(bus.o_in_ready), 32'd0);
        n = 0;
        while (!bus.o_done && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("halt_done",    32'(bus.o_done), 32'd1);
        check("halt_drained", 32'(sb.size()),  32'd0);
        set_ready(1'b1, 1'b1);
        drive(mk(1, 7'h13, 0, 0, 1, 0, 0, 7));
        bus.i_in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("done_in_ready",  32'(bus.o_in_ready),  32'd0);
            check("done_out_valid", 32'(bus.o_out_valid), 32'd0);
            check("done_count",     32'(bus.o_count),     32'(m_cnt));
            check("done_sticky",    32'(bus.o_done),      32'd1);
        end
        bus.i_in_valid = 1'b0;

        // Restart; out-of-range immediate, then illegal format
        do_start();
        send(mk(1, 7'h13, 0, 0, 2, 3, 0, 4096), 1'b0, 32'd0);
        send(mk(7, 7'h33, 1, 0, 1, 1, 1, 0),    1'b1, 32'h0000_0013);
        wait_drain("drain_err");

        // Reset with a word in flight
        set_ready(1'b1, 1'b0);
        send(mk(1, 7'h13, 0, 0, 6, 6, 0, 100), 1'b0, 32'd0);
        check("inflight_valid", 32'(bus.o_out_valid), 32'd1);
        rst = 1'b1;
        #2;
        check("rst2_out_valid", 32'(bus.o_out_valid), 32'd0);
        check("rst2_in_ready",  32'(bus.o_in_ready),  32'd0);
        check("rst2_out_instr", bus.o_out_instr,      32'd0);
        check("rst2_out_addr",  32'(bus.o_out_addr),  32'(BASE));
        check("rst2_count",     32'(bus.o_count),     32'd0);
        check("rst2_done",      32'(bus.o_done),      32'd0);
        check("rst2_err",       32'(bus.o_err),       32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        set_ready(1'b1, 1'b1);
        @(negedge clk);
        #1;
        check("idle_in_ready",  32'(bus.o_in_ready),  32'd0);
        check("idle_out_valid", 32'(bus.o_out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
